// File: rtl/drum_init_gen_pkg.sv
// Shared types and helpers for the drum mesh initial-condition generator.
package drum_init_pkg;

    localparam int NODE_W = 18;
    localparam logic [NODE_W-1:0] ONE_HALF = 18'h10000;

    typedef enum logic [1:0] {
        PYRAMID = 2'd0,
        FLAT    = 2'd1,
        ZERO    = 2'd2,
        IMPULSE = 2'd3
    } init_mode_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_DIV,
        S_STREAM,
        S_DONE
    } gen_state_t;

    // Distance of a node from the nearest grid edge; edge nodes are ring 0.
    function automatic int ring_dist(input int row, input int col, input int rows, input int cols);
        int d;
        d = row;
        if (col < d)             d = col;
        if (rows - 1 - row < d)  d = rows - 1 - row;
        if (cols - 1 - col < d)  d = cols - 1 - col;
        return d;
    endfunction

endpackage

// File: rtl/drum_init_gen_if.sv
// Node stream from the generator to the mesh loader, valid/ready handshake.
interface drum_init_gen_if #(
    parameter int DATA_W = 18,
    parameter int IDX_W  = 10
);
    logic              out_valid;
    logic              out_ready;
    logic [IDX_W-1:0]  out_row;
    logic [IDX_W-1:0]  out_col;
    logic [DATA_W-1:0] out_value;
    logic              out_last;

    modport master (output out_valid, out_row, out_col, out_value, out_last, input out_ready);
    modport slave  (input out_valid, out_row, out_col, out_value, out_last, output out_ready);
endinterface

// File: rtl/drum_init_gen_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, round-half-up result.
module drum_init_divider #(
    parameter int DATA_W = 18
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              i_start,
    input  logic [DATA_W-1:0] i_dividend,
    input  logic [DATA_W-1:0] i_divisor,
    output logic              o_done,
    output logic [DATA_W-1:0] o_quotient
);
    localparam int CNT_W = $clog2(DATA_W + 1);

    logic              r_active;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_rem;
    logic [DATA_W-1:0] r_quo;
    logic [DATA_W-1:0] r_div;
    logic [DATA_W:0]   w_rem_shift;
    logic [DATA_W:0]   w_diff;
    logic              w_ge;
    logic              w_round;

    assign w_rem_shift = {r_rem, r_quo[DATA_W-1]};
    assign w_ge        = w_rem_shift >= {1'b0, r_div};
    assign w_diff      = w_rem_shift - {1'b0, r_div};
    assign w_round     = {r_rem, 1'b0} >= {1'b0, r_div};
    assign o_done      = r_active && (r_cnt == CNT_W'(DATA_W));
    assign o_quotient  = r_quo + DATA_W'(w_round);

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_active <= 1'b0;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
        end else if (i_start) begin
            r_active <= 1'b1;
            r_cnt    <= '0;
            r_rem    <= '0;
            r_quo    <= i_dividend;
            r_div    <= i_divisor;
        end else if (r_active) begin
            if (r_cnt == CNT_W'(DATA_W)) begin
                r_active <= 1'b0;
            end else begin
                r_rem <= w_ge ? w_diff[DATA_W-1:0] : w_rem_shift[DATA_W-1:0];
                r_quo <= {r_quo[DATA_W-2:0], w_ge};
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/drum_init_gen.sv
// Streams the initial displacement of every drum mesh node in column-major order.
module drum_init_gen
    import drum_init_pkg::*;
#(
    parameter int ROWS   = 30,
    parameter int COLS   = 30,
    parameter int DATA_W = NODE_W,
    parameter int IDX_W  = 10
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [1:0]        mode_in,
    input  logic [DATA_W-1:0] peak_in,
    drum_init_gen_if.master   out_if,
    output logic              busy,
    output logic              done
);
    localparam int MAXRING = (((ROWS < COLS) ? ROWS : COLS) - 1) / 2;
    localparam int PROD_W  = DATA_W + IDX_W;

    gen_state_t        r_state, w_next_state;
    init_mode_t        r_mode;
    logic [DATA_W-1:0] r_peak;
    logic [IDX_W-1:0]  r_row, r_col;
    logic              r_valid, r_last;
    logic [IDX_W-1:0]  r_out_row, r_out_col;
    logic [DATA_W-1:0] r_out_value;

    logic              w_start_frame, w_div_done, w_accept, w_load, w_frame_end;
    logic              w_is_max, w_is_center, w_node_last;
    logic [DATA_W-1:0] w_step, w_value;
    logic [IDX_W-1:0]  w_ring;
    logic [PROD_W-1:0] w_prod;

    drum_init_divider #(.DATA_W(DATA_W)) u_div (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_start    (w_start_frame),
        .i_dividend (peak_in),
        .i_divisor  (DATA_W'(MAXRING)),
        .o_done     (w_div_done),
        .o_quotient (w_step)
    );

    assign w_start_frame = (r_state == S_IDLE) && start;
    assign w_accept      = r_valid && out_if.out_ready;
    assign w_frame_end   = (r_state == S_STREAM) && w_accept && r_last;
    assign w_load        = ((r_state == S_DIV) && w_div_done)
                         || ((r_state == S_STREAM) && w_accept && !r_last);

    // r_row/r_col address the node that will be loaded next into the output register.
    assign w_ring      = IDX_W'(ring_dist(int'(r_row), int'(r_col), ROWS, COLS));
    assign w_prod      = PROD_W'(w_ring) * PROD_W'(w_step);
    assign w_is_max    = w_ring == IDX_W'(MAXRING);
    assign w_is_center = (r_row == IDX_W'(ROWS / 2)) && (r_col == IDX_W'(COLS / 2));
    assign w_node_last = (r_row == IDX_W'(ROWS - 1)) && (r_col == IDX_W'(COLS - 1));

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        w_value = '0;
        case (r_mode)
            PYRAMID: begin
                if (w_is_max)                        w_value = r_peak;
                else if (w_prod > PROD_W'(r_peak))   w_value = r_peak;
                else                                 w_value = w_prod[DATA_W-1:0];
            end
            FLAT:    w_value = r_peak;
            ZERO:    w_value = '0;
            IMPULSE: if (w_is_center) w_value = r_peak;
            default: w_value = '0;
        endcase
        if (w_ring == '0) w_value = '0;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   if (start)       w_next_state = S_DIV;
            S_DIV:    if (w_div_done)  w_next_state = S_STREAM;
            S_STREAM: if (w_frame_end) w_next_state = S_DONE;
            S_DONE:                    w_next_state = S_IDLE;
            default:                   w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next_state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_mode <= PYRAMID;
            r_peak <= '0;
            r_row  <= '0;
            r_col  <= '0;
        end else if (w_start_frame) begin
            r_mode <= init_mode_t'(mode_in);
            r_peak <= peak_in;
            r_row  <= '0;
            r_col  <= '0;
        end else if (w_load) begin
            if (r_row == IDX_W'(ROWS - 1)) begin
                r_row <= '0;
                r_col <= r_col + IDX_W'(1);
            end else begin
                r_row <= r_row + IDX_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_out_row   <= '0;
            r_out_col   <= '0;
            r_out_value <= '0;
        end else if (w_load) begin
            r_valid     <= 1'b1;
            r_last      <= w_node_last;
            r_out_row   <= r_row;
            r_out_col   <= r_col;
            r_out_value <= w_value;
        end else if (w_frame_end) begin
            r_valid     <= 1'b0;
        end
    end

    assign out_if.out_valid = r_valid;
    assign out_if.out_last  = r_last;
    assign out_if.out_row   = r_out_row;
    assign out_if.out_col   = r_out_col;
    assign out_if.out_value = r_out_value;
    assign busy             = r_state != S_IDLE;
    assign done             = r_state == S_DONE;
endmodule

// File: doc/drum_init_gen.md
# drum_init_gen

Parametrised, sequential initial-condition generator for the drum mesh. On `start` it streams the displacement for every node of a ROWS×COLS grid in column-major order over a valid/ready handshake. The mesh-loader writes the stream into the per-column node memories. Shape and peak amplitude are selected at run time, and the per-ring slope is derived on chip by a sequential divider, so no per-size constant table is needed.

## Interface
Parameters:
- `ROWS`, default 30: grid rows, ≥3.
- `COLS`, default 30: grid columns, ≥3.
- `DATA_W`, default 18: node value width, signed 1.17 fixed point.
- `IDX_W`, default 10: row/column index width; requires 2^IDX_W ≥ max(ROWS,COLS).

Ports:
- `clk` in 1: system clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a frame; sampled only in IDLE.
- `mode_in` in 2: shape, latched at start. 0 PYRAMID, 1 FLAT, 2 ZERO, 3 IMPULSE.
- `peak_in` in DATA_W: peak amplitude, latched at start; treated as non-negative.
- `out_valid` out 1: node value available.
- `out_ready` in 1: consumer accepts the node on `out_valid && out_ready`.
- `out_row` out IDX_W: row index of the current node.
- `out_col` out IDX_W: column index of the current node.
- `out_value` out DATA_W: node displacement.
- `out_last` out 1: current node is (ROWS-1, COLS-1).
- `busy` out 1: high outside IDLE.
- `done` out 1: one-cycle pulse when the frame is complete.

## Operation
- Definitions:
  - MAXRING = (min(ROWS,COLS)-1)/2, integer division.
  - ring(r,c) = min(r, c, ROWS-1-r, COLS-1-c). Boundary nodes have ring 0.
- State machine: IDLE → DIV → STREAM → DONE → IDLE.
- IDLE:
  - On `start`, latch `mode_in` and `peak_in`, clear the row and column counters, and enter DIV.
- DIV:
  - Runs for exactly DATA_W cycles regardless of mode.
  - Computes STEP = round(peak / MAXRING), round-half-up, unsigned restoring division.
- STREAM:
  - Emits nodes in column-major order: row increments fastest, column advances when row wraps from ROWS-1 to 0.
  - Values by mode:
    - PYRAMID: ring==MAXRING gives peak exactly; otherwise min(ring·STEP, peak). The product is formed at DATA_W+IDX_W bits before the clamp.
    - FLAT: 0 on the boundary, peak elsewhere.
    - ZERO: 0 everywhere.
    - IMPULSE: peak at (ROWS/2, COLS/2), 0 elsewhere.
  - The boundary is always 0 in every mode (fixed drum edge).
- DONE: asserts `done` for one cycle, then returns to IDLE.
- `start` in any state other than IDLE is ignored; latched mode and peak are not disturbed.
- `reset_n` low at any time, including mid-DIV or mid-STREAM, aborts immediately:
  - The frame is not resumed.
  - The consumer restarts the load after the next `start`.

## Timing
- Reset values: `out_valid` 0, `out_row` 0, `out_col` 0, `out_value` 0, `out_last` 0, `busy` 0, `done` 0, state IDLE.
- Frame start:
  - Cycle of `start`: `busy` rises on the next edge.
  - First `out_valid` rises DATA_W+1 edges after the `start` edge.
- Output registers:
  - `out_row`, `out_col`, `out_value` and `out_last` are registered together.
  - They stay stable while `out_valid && !out_ready`.
  - `out_valid` never drops without an accept.
- Throughput: one node per cycle when `out_ready` is held high.
  - ROWS·COLS accepts complete a frame.
- Frame end:
  - `out_valid` falls on the edge after the accept of the `out_last` node.
  - `done` is high for the following cycle.
  - `busy` falls on the edge after `done`.
- A `start` on the cycle `busy` falls is accepted.
- Back-to-back frames: the minimum gap is 1 IDLE cycle.

## Structure
- Package `drum_init_pkg`:
  - `init_mode_t` enum: PYRAMID, FLAT, ZERO, IMPULSE.
  - `NODE_W` = 18 default.
  - Fixed-point `ONE_HALF` = 18'h10000.
  - Helper function for ring distance.
- Sub-module `drum_init_divider`:
  - Sequential restoring divider with a start/done pair.
  - DATA_W-cycle latency, round-half-up remainder compare.
  - Reused later for damping-coefficient setup.
- Top-level contents: FSM, row/column counters, ring logic, one multiplier, clamp and output register.

## Test plan
- 30×30 PYRAMID with peak 18'h10000, `out_ready` held high:
  - STEP = 18'h1249.
  - (0,x) and (x,0) give 0; ring 1 gives 18'h1249; ring 13 gives 18'hEDB5.
  - (14,14), (14,15), (15,14) and (15,15) give 18'h10000.
  - Exactly 900 accepts; `out_last` on (29,29); `done` 1 cycle later.
- 5×8 FLAT with peak 18'h08000:
  - Nodes with ring 0 give 0; all 18 interior nodes give 18'h08000.
  - Column-major order checked against the indices.
- 30×30 IMPULSE with peak 18'h04000: only (15,15) gives 18'h04000; the other 899 nodes give 0.
- Random `out_ready` backpressure, 50% duty:
  - Outputs stay stable while stalled; no drops or duplicates.
  - Sequence is identical to the unstalled run.
- Reset and ignored start:
  - `reset_n` low during node 400: all outputs return to their reset values and the state is IDLE.
  - A `start` issued during STREAM is ignored.
  - A new `start` produces a full 900-node frame from (0,0).
